// File: rtl/acx_reg_bus_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
package acx_reg_bus_pkg;

    localparam int BUS_DATA_WIDTH = 32;
    localparam int STRB_WIDTH     = BUS_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ACC,
        ST_RD_ACC,
        ST_WR_RESP,
        ST_RD_RESP,
        ST_GAP
    } reg_bridge_state_t;

endpackage

// File: rtl/acx_axi_hold_reg.sv
// One-entry valid/ready holding register; loads on handshake, empties on i_free.
// Ready stays low until the first clock after reset, then tracks !full.
module acx_axi_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic             i_free,
    output logic             o_full,
    output logic [WIDTH-1:0] o_dat
);

    logic live;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            live   <= 1'b0;
            o_full <= 1'b0;
            o_dat  <= '0;
        end else begin
            live <= 1'b1;
            if (i_vld && o_rdy) begin
                o_full <= 1'b1;
                o_dat  <= i_dat;
            end else if (i_free) begin
                o_full <= 1'b0;
            end
        end
    end

    assign o_rdy = live && !o_full;

endmodule

// File: rtl/acx_axi_slave_reg_bridge.sv
// AXI4-Lite slave driving the register strobe bus, one access at a time, with hit timeout.
// Write/read alternate when both are pending; a one-cycle GAP swallows the trailing decode hit.
module acx_axi_slave_reg_bridge
    import acx_reg_bus_pkg::*;
#(
    parameter int                        TGT_ADDR_WIDTH = 28,
    parameter int                        TGT_DATA_WIDTH = 32,
    parameter int                        TIMEOUT_CYCLES = 16,
    parameter logic [TGT_DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [TGT_ADDR_WIDTH-1:0] i_awaddr,
    input  logic                      i_awvalid,
    output logic                      o_awready,
    input  logic [TGT_DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0]     i_wstrb,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [1:0]                o_bresp,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    input  logic [TGT_ADDR_WIDTH-1:0] i_araddr,
    input  logic                      i_arvalid,
    output logic                      o_arready,
    output logic [TGT_DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]                o_rresp,
    output logic                      o_rvalid,
    input  logic                      i_rready,
    output logic [STRB_WIDTH-1:0]     o_wr,
    output logic                      o_rd,
    output logic [TGT_ADDR_WIDTH-1:0] o_addr,
    output logic [TGT_DATA_WIDTH-1:0] o_write_data,
    input  logic                      i_addr_hit,
    input  logic [TGT_DATA_WIDTH-1:0] i_read_data
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) + 1 < 5) ? 5 : $clog2(TIMEOUT_CYCLES) + 1;
    localparam int WH_W  = STRB_WIDTH + TGT_DATA_WIDTH;

    reg_bridge_state_t state, state_nxt;

    logic                      aw_full, w_full, ar_full;
    logic                      free_aw, free_w, free_ar;
    logic [TGT_ADDR_WIDTH-1:0] aw_dat, ar_dat;
    logic [WH_W-1:0]           w_dat;
    logic [STRB_WIDTH-1:0]     w_strb;

    logic [STRB_WIDTH-1:0]     wr_nxt;
    logic                      rd_nxt;
    logic [TGT_ADDR_WIDTH-1:0] addr_nxt;
    logic [TGT_DATA_WIDTH-1:0] wdat_nxt, rdata_nxt;
    logic [1:0]                resp, resp_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      last_wr, last_wr_nxt;
    logic                      wr_pend, rd_pend;

    acx_axi_hold_reg #(.WIDTH(TGT_ADDR_WIDTH)) u_aw_hold (
        .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_awaddr), .i_vld(i_awvalid), .o_rdy(o_awready),
        .i_free(free_aw), .o_full(aw_full), .o_dat(aw_dat)
    );

    acx_axi_hold_reg #(.WIDTH(WH_W)) u_w_hold (
        .i_clk(i_clk), .i_rst(i_rst), .i_dat({i_wstrb, i_wdata}), .i_vld(i_wvalid), .o_rdy(o_wready),
        .i_free(free_w), .o_full(w_full), .o_dat(w_dat)
    );

    acx_axi_hold_reg #(.WIDTH(TGT_ADDR_WIDTH)) u_ar_hold (
        .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_araddr), .i_vld(i_arvalid), .o_rdy(o_arready),
        .i_free(free_ar), .o_full(ar_full), .o_dat(ar_dat)
    );

    assign wr_pend = aw_full && w_full;
    assign rd_pend = ar_full;
    assign w_strb  = w_dat[TGT_DATA_WIDTH +: STRB_WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_wr         <= '0;
            o_rd         <= 1'b0;
            o_addr       <= '0;
            o_write_data <= '0;
            o_rdata      <= '0;
            resp         <= RESP_OKAY;
            cnt          <= '0;
            last_wr      <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_wr         <= wr_nxt;
            o_rd         <= rd_nxt;
            o_addr       <= addr_nxt;
            o_write_data <= wdat_nxt;
            o_rdata      <= rdata_nxt;
            resp         <= resp_nxt;
            cnt          <= cnt_nxt;
            last_wr      <= last_wr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_nxt      = o_wr;
        rd_nxt      = o_rd;
        addr_nxt    = o_addr;
        wdat_nxt    = o_write_data;
        rdata_nxt   = o_rdata;
        resp_nxt    = resp;
        cnt_nxt     = cnt;
        last_wr_nxt = last_wr;
        free_aw     = 1'b0;
        free_w      = 1'b0;
        free_ar     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_pend && (!rd_pend || !last_wr)) begin
                    free_aw     = 1'b1;
                    free_w      = 1'b1;
                    last_wr_nxt = 1'b1;
                    cnt_nxt     = '0;
                    addr_nxt    = {aw_dat[TGT_ADDR_WIDTH-1:2], 2'b00};
                    wdat_nxt    = w_dat[TGT_DATA_WIDTH-1:0];
                    // An all-zero strobe write touches nothing, so it completes without a bus access.
                    if (w_strb == '0) begin
                        resp_nxt  = RESP_OKAY;
                        state_nxt = ST_WR_RESP;
                    end else begin
                        wr_nxt    = w_strb;
                        state_nxt = ST_WR_ACC;
                    end
                end else if (rd_pend) begin
                    free_ar     = 1'b1;
                    last_wr_nxt = 1'b0;
                    cnt_nxt     = '0;
                    addr_nxt    = {ar_dat[TGT_ADDR_WIDTH-1:2], 2'b00};
                    rd_nxt      = 1'b1;
                    state_nxt   = ST_RD_ACC;
                end
            end
            ST_WR_ACC, ST_RD_ACC: begin
                if (i_addr_hit) begin
                    wr_nxt   = '0;
                    rd_nxt   = 1'b0;
                    resp_nxt = RESP_OKAY;
                    if (state == ST_RD_ACC) rdata_nxt = i_read_data;
                    state_nxt = (state == ST_WR_ACC) ? ST_WR_RESP : ST_RD_RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wr_nxt   = '0;
                    rd_nxt   = 1'b0;
                    resp_nxt = RESP_SLVERR;
                    if (state == ST_RD_ACC) rdata_nxt = TIMEOUT_DATA;
                    state_nxt = (state == ST_WR_ACC) ? ST_WR_RESP : ST_RD_RESP;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WR_RESP: if (i_bready) state_nxt = ST_GAP;
            ST_RD_RESP: if (i_rready) state_nxt = ST_GAP;
            ST_GAP:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign o_bvalid = (state == ST_WR_RESP);
    assign o_rvalid = (state == ST_RD_RESP);
    assign o_bresp  = o_bvalid ? resp : RESP_OKAY;
    assign o_rresp  = o_rvalid ? resp : RESP_OKAY;

endmodule

// File: doc/acx_axi_slave_reg_bridge.md
Name: acx_axi_slave_reg_bridge

Overview:
AXI4-Lite slave that converts host register transactions into the internal per-register strobe bus (byte-write strobes, read strobe, address, write data). It feeds every slave register on the target bus and collects their registered address-hit and the pre-muxed read data. It sits directly upstream of the register bank and handles one access at a time. If no register claims an access within a bounded time, it completes the access with an error response.

Parameters:
TGT_ADDR_WIDTH, 28, register-bus and AXI address width (byte address)
TGT_DATA_WIDTH, 32, data width; fixed at 32, with 4 byte strobes
TIMEOUT_CYCLES, 16, number of cycles without a hit before the access is aborted; must be >= 4
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
i_clk  in  1  clock; the only clock in the block
i_rst  in  1  reset; asynchronous assert, active-high
i_awaddr  in  TGT_ADDR_WIDTH  AXI write address
i_awvalid  in  1  write address valid
o_awready  out  1  write address ready
i_wdata  in  32  write data
i_wstrb  in  4  write byte strobes
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
o_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
i_araddr  in  TGT_ADDR_WIDTH  AXI read address
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
o_rdata  out  32  read data
o_rresp  out  2  read response
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_wr  out  4  register-bus byte write strobes
o_rd  out  1  register-bus read strobe
o_addr  out  TGT_ADDR_WIDTH  register-bus address
o_write_data  out  32  register-bus write data
i_addr_hit  in  1  OR of all register address-hit outputs
i_read_data  in  32  selected register read data; valid while i_addr_hit is 1

Behaviour:
- Reset values: all ready/valid outputs, o_wr, o_rd and responses are 0; o_addr, o_write_data and o_rdata are 0. Holding registers are empty and the arbiter favours write.
- Three 1-entry holding registers: AW, W and AR.
  - o_awready = !aw_full; o_wready = !w_full; o_arready = !ar_full.
  - A holding register is loaded on its valid&ready handshake and freed when its access is granted.
- FSM states: IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP, GAP.
- IDLE: a write is pending when aw_full & w_full; a read is pending when ar_full.
  - If both are pending, alternate using a last-granted flag.
  - On grant, o_addr is driven from the holding address with bits [1:0] forced to 0.
  - Write grant: o_write_data = wdata, o_wr = wstrb (if wstrb == 0, o_wr = 4'b0000, no bus access is made, and the FSM goes straight to WR_RESP with OKAY).
  - Read grant: o_rd = 1.
  - Transition to WR_ACC or RD_ACC.
- WR_ACC / RD_ACC: strobes and address are held stable. The first i_addr_hit arrives 2 cycles after the strobes are first driven at the earliest.
  - On i_addr_hit: drop the strobes, capture i_read_data into o_rdata (read), set resp = OKAY, go to *_RESP.
  - Otherwise, when the cycle counter reaches TIMEOUT_CYCLES-1: drop the strobes, set resp = SLVERR, o_rdata = TIMEOUT_DATA, go to *_RESP.
- *_RESP: assert o_bvalid or o_rvalid, holding data and resp stable until i_bready / i_rready, then go to GAP.
- GAP: exactly one cycle; i_addr_hit is ignored, which absorbs the trailing hit from the registered decode. Then return to IDLE.
- Strobes held for the 2-cycle decode may produce a repeated write of the identical data. This is permitted; all registers are idempotent per access.
- New AXI handshakes into free holding registers are accepted in any state. Only one register-bus access is outstanding at a time.
- Reset asserted mid-access: everything clears immediately (asynchronously). No response is issued for the in-flight access.
- The timeout counter is 5 bits or wider, saturates, and clears on every grant.

Decomposition:
- Package acx_reg_bus_pkg holds:
  - enum reg_bridge_state_t
  - AXI response constants RESP_OKAY and RESP_SLVERR
  - TGT_DATA_WIDTH-derived strobe width localparam
- One sub-module, acx_axi_hold_reg: a 1-entry valid/ready holding register, instantiated for AW, W and AR.

Test Plan:
- AXI write 0x0000_0010, data 0x1234_5678, wstrb 4'hF; the register model hits 2 cycles after o_wr -> o_wr = 4'hF seen on the bus, bresp = 2'b00, bvalid until bready.
- AXI read 0x0000_0014; the model returns 0xCAFE_0001 with the hit -> rdata = 0xCAFE_0001, rresp = 00, o_rd dropped the cycle after the hit.
- Read of an unmapped 0x0FFF_FFF0, no hit -> after 16 cycles rresp = 2'b10, rdata = 0xDEAD_BEEF; the next access proceeds normally.
- AW and AR presented in the same cycle, each repeated 3 times -> the bus order is W, R, W, R, W, R; each response is correct.
- W arrives 5 cycles before AW -> no bus access until AW arrives; then a single write with the correct strobes, e.g. wstrb 4'b0101 -> o_wr = 4'b0101.
- i_rst pulsed during WR_ACC -> outputs are 0 in the same cycle, no bvalid, and a fresh write afterwards completes with OKAY.
